// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU (port 0) and peripheral/DMA (port 1) share
// one synchronous-read data memory. Grants are combinational in the request
// cycle; a requester may lock the grant for a bounded burst; read data is
// routed back to the granted port one cycle later.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner, round-robin arbitration between requesters
// OWN0  | port 0 holds a lock; granted whenever it requests
// OWN1  | port 1 holds a lock; granted whenever it requests
module mem_arbiter #(
   parameter int DATA_W    = 32,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic              r0_lock,
   input  logic [DATA_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic              r1_lock,
   input  logic [DATA_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // Burst timer counts down the grants still allowed to the lock owner;
   // the first grant of a burst is issued from IDLE, so it loads BURST_MAX-1.
   localparam logic [3:0] BURST_INIT = 4'(BURST_MAX - 1);

   state_t     state;
   logic       last_gnt;
   logic [3:0] burst_left;
   logic       rd0;
   logic       rd1;

   logic       hold0;
   logic       hold1;
   logic       gnt0;
   logic       gnt1;

   // Winner selection: lock owner first, otherwise round-robin on last_gnt.
   // An owner that drops req falls through to normal arbitration this cycle.
   always_comb begin
      hold0 = (state == OWN0) && r0_req;
      hold1 = (state == OWN1) && r1_req;
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      if (!rst) begin
         if (hold0) begin
            gnt0 = 1'b1;
         end else if (hold1) begin
            gnt1 = 1'b1;
         end else if (r0_req && r1_req) begin
            if (last_gnt) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else if (r0_req) begin
            gnt0 = 1'b1;
         end else if (r1_req) begin
            gnt1 = 1'b1;
         end
      end
   end

   // Lock FSM, burst timer, round-robin pointer and read-return tags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_gnt   <= 1'b1;
         burst_left <= 4'd0;
         rd0        <= 1'b0;
         rd1        <= 1'b0;
      end else begin
         rd0 <= gnt0 & ~r0_we;
         rd1 <= gnt1 & ~r1_we;

         if (gnt0) begin
            last_gnt <= 1'b0;
         end else if (gnt1) begin
            last_gnt <= 1'b1;
         end

         if (hold0) begin
            if (r0_lock && (burst_left > 4'd1)) begin
               burst_left <= burst_left - 4'd1;
            end else begin
               state      <= IDLE;
               burst_left <= 4'd0;
            end
         end else if (hold1) begin
            if (r1_lock && (burst_left > 4'd1)) begin
               burst_left <= burst_left - 4'd1;
            end else begin
               state      <= IDLE;
               burst_left <= 4'd0;
            end
         end else if (gnt0 && r0_lock && (BURST_INIT != 4'd0)) begin
            state      <= OWN0;
            burst_left <= BURST_INIT;
         end else if (gnt1 && r1_lock && (BURST_INIT != 4'd0)) begin
            state      <= OWN1;
            burst_left <= BURST_INIT;
         end else begin
            state      <= IDLE;
            burst_left <= 4'd0;
         end
      end
   end

   // Memory-side mux: everything zero when nobody is granted.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (gnt0) begin
         mem_addr  = r0_addr;
         mem_wdata = r0_wdata;
         mem_we    = r0_we;
      end else if (gnt1) begin
         mem_addr  = r1_addr;
         mem_wdata = r1_wdata;
         mem_we    = r1_we;
      end
   end

   // Read return; rst masks a tag set on the edge before reset was applied.
   always_comb begin
      r0_gnt    = gnt0;
      r1_gnt    = gnt1;
      r0_rvalid = rd0 & ~rst;
      r1_rvalid = rd1 & ~rst;
      r0_rdata  = r0_rvalid ? mem_rdata : '0;
      r1_rdata  = r1_rvalid ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed stimulus pushes expected grants and
// read returns into queues; a negedge monitor pops and compares them.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_req, r0_we, r0_lock;
   logic [31:0] r0_addr, r0_wdata;
   logic        r0_gnt, r0_rvalid;
   logic [31:0] r0_rdata;
   logic        r1_req, r1_we, r1_lock;
   logic [31:0] r1_addr, r1_wdata;
   logic        r1_gnt, r1_rvalid;
   logic [31:0] r1_rdata;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata = '0;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit run         = 1'b1;

   typedef struct {
      int          cyc;
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t gq[$];
   exp_t rq[$];

   logic [31:0] mem [0:255] = '{default: 32'h0};
   logic        wr  [0:255] = '{default: 1'b0};

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .r0_req    (r0_req),
      .r0_we     (r0_we),
      .r0_lock   (r0_lock),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_gnt    (r0_gnt),
      .r0_rvalid (r0_rvalid),
      .r0_rdata  (r0_rdata),
      .r1_req    (r1_req),
      .r1_we     (r1_we),
      .r1_lock   (r1_lock),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_gnt    (r1_gnt),
      .r1_rvalid (r1_rvalid),
      .r1_rdata  (r1_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read memory; unwritten words read back as F0F0F0 & address.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
         wr[mem_addr[7:0]]  <= 1'b1;
      end
      mem_rdata <= wr[mem_addr[7:0]] ? mem[mem_addr[7:0]] : {24'hF0F0F0, mem_addr[7:0]};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %h, required %h", name, cyc, act, exp);
      end
   endtask

   task automatic flag(input string name, input int port, input int ecyc);
      vectors++;
      miscompares++;
      $display("FAIL %s cycle %0d: port %0d, required cycle %0d", name, cyc, port, ecyc);
   endtask

   task automatic monitor_cycle();
      exp_t e;
      chk("double_gnt", 32'(r0_gnt & r1_gnt), 32'd0);
      if (r0_gnt || r1_gnt) begin
         if (gq.size() == 0) begin
            flag("unexpected_gnt", r1_gnt ? 1 : 0, -1);
         end else begin
            e = gq.pop_front();
            chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
            chk("gnt_port", 32'(r1_gnt), 32'(e.port));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wdata", mem_wdata, e.data);
         end
      end else begin
         if (gq.size() > 0 && gq[0].cyc <= cyc) begin
            e = gq.pop_front();
            flag("missing_gnt", e.port, e.cyc);
         end
         chk("idle_mem_we", 32'(mem_we), 32'd0);
         chk("idle_mem_addr", mem_addr, 32'd0);
         chk("idle_mem_wdata", mem_wdata, 32'd0);
      end
      chk("double_rvalid", 32'(r0_rvalid & r1_rvalid), 32'd0);
      if (r0_rvalid || r1_rvalid) begin
         if (rq.size() == 0) begin
            flag("unexpected_rvalid", r1_rvalid ? 1 : 0, -1);
         end else begin
            e = rq.pop_front();
            chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
            chk("rvalid_port", 32'(r1_rvalid), 32'(e.port));
            chk("rdata", r1_rvalid ? r1_rdata : r0_rdata, e.data);
         end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
         e = rq.pop_front();
         flag("missing_rvalid", e.port, e.cyc);
      end
      if (!r0_rvalid) chk("r0_rdata_idle", r0_rdata, 32'd0);
      if (!r1_rvalid) chk("r1_rdata_idle", r1_rdata, 32'd0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (run) monitor_cycle();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic req, we, lock, input logic [31:0] addr, wdata);
      r0_req = req; r0_we = we; r0_lock = lock; r0_addr = addr; r0_wdata = wdata;
   endtask

   task automatic drv1(input logic req, we, lock, input logic [31:0] addr, wdata);
      r1_req = req; r1_we = we; r1_lock = lock; r1_addr = addr; r1_wdata = wdata;
   endtask

   task automatic idle_all();
      drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic exp_g(input int port, input logic we, input logic [31:0] addr, wdata);
      exp_t e;
      e.cyc = cyc; e.port = port; e.we = we; e.addr = addr; e.data = wdata;
      gq.push_back(e);
   endtask

   task automatic exp_r(input int port, input logic [31:0] data);
      exp_t e;
      e.cyc = cyc + 1; e.port = port; e.we = 1'b0; e.addr = 32'h0; e.data = data;
      rq.push_back(e);
   endtask

   initial begin
      // reset with both ports requesting: nothing may be granted
      rst = 1'b1;
      drv0(1'b1, 1'b1, 1'b1, 32'h10, 32'h1234);
      drv1(1'b1, 1'b0, 1'b1, 32'h20, 32'h5678);
      step();
      step();

      // simultaneous reads after reset: r0 wins, then r1, returns in order
      rst = 1'b0;
      drv0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      drv1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      exp_g(0, 1'b0, 32'h10, 32'h0);
      exp_r(0, 32'hF0F0F010);
      step();
      drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      exp_g(1, 1'b0, 32'h20, 32'h0);
      exp_r(1, 32'hF0F0F020);
      step();
      idle_all();

      // both ports writing continuously: strict alternation 0,1,0,1,0,1
      for (int i = 0; i < 6; i++) begin
         step();
         drv0(1'b1, 1'b1, 1'b0, 32'h80 + 32'((i + 1) / 2), 32'h0A000000 + 32'((i + 1) / 2));
         drv1(1'b1, 1'b1, 1'b0, 32'h90 + 32'(i / 2), 32'h0B000000 + 32'(i / 2));
         if (i % 2 == 0) exp_g(0, 1'b1, 32'h80 + 32'(i / 2), 32'h0A000000 + 32'(i / 2));
         else            exp_g(1, 1'b1, 32'h90 + 32'(i / 2), 32'h0B000000 + 32'(i / 2));
      end
      step();
      idle_all();

      // r1 locked burst of 4 with r0 waiting; r0 wins the 5th cycle
      step();
      drv1(1'b1, 1'b1, 1'b1, 32'hA0, 32'h0C0C0C0C);
      exp_g(1, 1'b1, 32'hA0, 32'h0C0C0C0C);
      for (int k = 1; k < 4; k++) begin
         step();
         drv0(1'b1, 1'b1, 1'b0, 32'hB0, 32'h0D0D0D0D);
         exp_g(1, 1'b1, 32'hA0, 32'h0C0C0C0C);
      end
      step();
      exp_g(0, 1'b1, 32'hB0, 32'h0D0D0D0D);
      step();
      idle_all();

      // r0 locked, drops req for one cycle: r1 granted that cycle, then IDLE
      step();
      drv0(1'b1, 1'b1, 1'b1, 32'hC0, 32'h11111111);
      exp_g(0, 1'b1, 32'hC0, 32'h11111111);
      step();
      drv1(1'b1, 1'b1, 1'b0, 32'hD0, 32'h22222222);
      exp_g(0, 1'b1, 32'hC0, 32'h11111111);
      step();
      drv0(1'b0, 1'b1, 1'b1, 32'hC0, 32'h11111111);
      exp_g(1, 1'b1, 32'hD0, 32'h22222222);
      step();
      drv0(1'b1, 1'b1, 1'b0, 32'hC4, 32'h33333333);
      exp_g(0, 1'b1, 32'hC4, 32'h33333333);
      step();
      idle_all();

      // reset in the middle of an r1 burst: lock must be gone afterwards
      step();
      drv1(1'b1, 1'b1, 1'b1, 32'hE0, 32'h44444444);
      exp_g(1, 1'b1, 32'hE0, 32'h44444444);
      step();
      rst = 1'b1;
      drv0(1'b1, 1'b1, 1'b0, 32'hE4, 32'h55555555);
      step();
      rst = 1'b0;
      exp_g(0, 1'b1, 32'hE4, 32'h55555555);
      step();
      idle_all();
      rst = 1'b1;

      // reset restores the round-robin pointer so port 0 wins the tie
      step();
      rst = 1'b0;
      drv0(1'b1, 1'b1, 1'b0, 32'hE8, 32'h66666666);
      drv1(1'b1, 1'b1, 1'b0, 32'hEC, 32'h77777777);
      exp_g(0, 1'b1, 32'hE8, 32'h66666666);
      step();
      idle_all();

      // reset right after an r1 read grant: its rvalid never appears
      step();
      drv1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      exp_g(1, 1'b0, 32'h20, 32'h0);
      step();
      rst = 1'b1;
      drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drv0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      step();
      rst = 1'b0;
      idle_all();

      // write through port 0, read back through port 1
      step();
      drv0(1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
      exp_g(0, 1'b1, 32'h40, 32'hDEADBEEF);
      step();
      drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drv1(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
      exp_g(1, 1'b0, 32'h40, 32'h0);
      exp_r(1, 32'hDEADBEEF);
      step();
      idle_all();

      // back-to-back alternating reads of the earlier writes, no bubbles
      for (int i = 0; i < 4; i++) begin
         step();
         drv0(1'b1, 1'b0, 1'b0, 32'h80 + 32'((i + 1) / 2), 32'h0);
         drv1(1'b1, 1'b0, 1'b0, 32'h90 + 32'(i / 2), 32'h0);
         if (i % 2 == 0) begin
            exp_g(0, 1'b0, 32'h80 + 32'(i / 2), 32'h0);
            exp_r(0, 32'h0A000000 + 32'(i / 2));
         end else begin
            exp_g(1, 1'b0, 32'h90 + 32'(i / 2), 32'h0);
            exp_r(1, 32'h0B000000 + 32'(i / 2));
         end
      end
      step();
      idle_all();
      step();
      step();
      @(negedge clk);
      #1;
      run = 1'b0;

      while (gq.size() > 0) begin
         flag("leftover_gnt", gq[0].port, gq[0].cyc);
         void'(gq.pop_front());
      end
      while (rq.size() > 0) begin
         flag("leftover_rvalid", rq[0].port, rq[0].cyc);
         void'(rq.pop_front());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
